// File: rtl/div_clk_tick_monitor.sv
// div_clk_tick_monitor: turns a divided clock into clk-domain rising-edge ticks,
// measures its period/high time in clk cycles and flags a stall when edges stop.
module div_clk_tick_monitor #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             enable,
  input  logic             clk_div,
  output logic             tick,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period_cyc,
  output logic [CNT_W-1:0] high_cyc,
  output logic             stalled
);
  typedef enum logic [1:0] {IDLE, MEASURE, STALLED} state_t;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
  state_t           state_q;
  logic             s1_q, s2_q, s3_q;
  logic             tick_q, valid_q, stalled_q;
  logic [CNT_W-1:0] cyc_q, hi_q, period_q, high_q;
  logic             rise;
  logic [CNT_W-1:0] cyc_d, hi_d;
  assign rise  = s2_q & ~s3_q;
  assign cyc_d = (cyc_q == MAX) ? cyc_q : cyc_q + ONE;
  assign hi_d  = (s2_q && hi_q != MAX) ? hi_q + ONE : hi_q;
  assign tick       = tick_q;
  assign meas_valid = valid_q;
  assign period_cyc = period_q;
  assign high_cyc   = high_q;
  assign stalled    = stalled_q;
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= IDLE;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      tick_q    <= 1'b0;
      valid_q   <= 1'b0;
      stalled_q <= 1'b0;
      cyc_q     <= '0;
      hi_q      <= '0;
      period_q  <= '0;
      high_q    <= '0;
    end else begin
      s1_q    <= clk_div;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      tick_q  <= rise & enable;
      valid_q <= 1'b0;
      if (!enable) begin
        state_q   <= IDLE;
        cyc_q     <= '0;
        hi_q      <= '0;
        stalled_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (rise) begin
            state_q <= MEASURE;
            cyc_q   <= ONE;
            hi_q    <= ONE;
          end
          MEASURE: if (rise) begin
            period_q <= cyc_q;
            high_q   <= hi_q;
            valid_q  <= 1'b1;
            cyc_q    <= ONE;
            hi_q     <= ONE;
          end else begin
            cyc_q <= cyc_d;
            hi_q  <= hi_d;
            if (cyc_q == TO) begin
              state_q   <= STALLED;
              stalled_q <= 1'b1;
            end
          end
          // the interval spanning a stall is meaningless, so restart without a measurement
          STALLED: if (rise) begin
            state_q   <= MEASURE;
            stalled_q <= 1'b0;
            cyc_q     <= ONE;
            hi_q      <= ONE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_div_clk_tick_monitor.sv
// tb_div_clk_tick_monitor: directed and random clk_div waveforms checked every cycle
// against an edge-history reference model.
module tb_div_clk_tick_monitor;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 16;
  localparam int MAXV    = 2**CNT_W - 1;
  logic             clk = 1'b0;
  logic             arst_n, enable, clk_div;
  logic             tick, meas_valid, stalled;
  logic [CNT_W-1:0] period_cyc, high_cyc;
  int               n_tests = 0;
  int               n_fail  = 0;
  bit               dh[$];
  bit               armed, m_stall, exp_tick, exp_mv;
  int               lr, exp_per, exp_hi;

  div_clk_tick_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .clk_div(clk_div),
    .tick(tick), .meas_valid(meas_valid), .period_cyc(period_cyc),
    .high_cyc(high_cyc), .stalled(stalled)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // synchronised level seen by the edge detector at edge e: clk_div from two edges earlier
  function automatic bit v(input int e);
    return (e >= 2) ? dh[e-2] : 1'b0;
  endfunction

  function automatic int sat(input int x);
    return (x > MAXV) ? MAXV : x;
  endfunction

  task automatic model_reset();
    dh.delete();
    armed = 0; m_stall = 0; exp_tick = 0; exp_mv = 0;
    lr = 0; exp_per = 0; exp_hi = 0;
  endtask

  task automatic cyc(input bit en, input bit d);
    int e, h;
    bit rise;
    enable  = en;
    clk_div = d;
    @(posedge clk);
    dh.push_back(d);
    e = dh.size() - 1;
    rise = v(e) && !v(e-1);
    exp_tick = en && rise;
    exp_mv   = 0;
    if (!en) begin
      armed = 0; m_stall = 0;
    end else if (rise) begin
      if (armed && !m_stall) begin
        h = 0;
        for (int i = lr; i < e; i++) h += int'(v(i));
        exp_mv  = 1;
        exp_per = sat(e - lr);
        exp_hi  = sat(h);
      end
      armed = 1; m_stall = 0; lr = e;
    end else if (armed && !m_stall && e - lr == TIMEOUT) begin
      m_stall = 1;
    end
    #1;
    chk("tick", 32'(tick), 32'(exp_tick));
    chk("meas_valid", 32'(meas_valid), 32'(exp_mv));
    chk("period_cyc", 32'(period_cyc), 32'(exp_per));
    chk("high_cyc", 32'(high_cyc), 32'(exp_hi));
    chk("stalled", 32'(stalled), 32'(m_stall));
  endtask

  task automatic pulse(input int hi, input int lo);
    repeat (hi) cyc(1'b1, 1'b1);
    repeat (lo) cyc(1'b1, 1'b0);
  endtask

  task automatic do_reset();
    arst_n  = 1'b0;
    clk_div = 1'b0;
    #1;
    chk("rst_tick", 32'(tick), 0);
    chk("rst_valid", 32'(meas_valid), 0);
    chk("rst_period", 32'(period_cyc), 0);
    chk("rst_high", 32'(high_cyc), 0);
    chk("rst_stalled", 32'(stalled), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    enable = 1'b0;
    model_reset();
    do_reset();
    // 2 high / 2 low
    repeat (6) pulse(2, 2);
    chk("s1_period", 32'(period_cyc), 4);
    chk("s1_high", 32'(high_cyc), 2);
    // 3 high / 2 low
    repeat (6) pulse(3, 2);
    chk("s2_period", 32'(period_cyc), 5);
    chk("s2_high", 32'(high_cyc), 3);
    // stuck low -> stall, recovery edge gives no measurement
    repeat (3) pulse(2, 2);
    repeat (20) cyc(1'b1, 1'b0);
    chk("s3_stalled", 32'(stalled), 1);
    pulse(2, 2);
    chk("s3_cleared", 32'(stalled), 0);
    repeat (2) pulse(2, 2);
    chk("s3_period", 32'(period_cyc), 4);
    // enable dropped mid-period
    repeat (4) pulse(2, 2);
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("s4_hold", 32'(period_cyc), 4);
    repeat (4) pulse(2, 2);
    // async reset mid-measure
    pulse(2, 2);
    cyc(1'b1, 1'b1);
    #2;
    do_reset();
    repeat (5) pulse(2, 2);
    chk("s5_period", 32'(period_cyc), 4);
    // divider running at div 6, then div 7
    repeat (8) pulse(3, 3);
    chk("s6_period6", 32'(period_cyc), 6);
    repeat (8) pulse(3, 4);
    chk("s6_period7", 32'(period_cyc), 7);
    chk("s6_high7", 32'(high_cyc), 3);
    // random waveforms, occasional enable drops and long stalls
    repeat (300) begin
      int hi, lo;
      hi = $urandom_range(1, 8);
      lo = ($urandom_range(0, 15) == 0) ? $urandom_range(14, 24) : $urandom_range(1, 8);
      repeat (hi) cyc($urandom_range(0, 29) != 0, 1'b1);
      repeat (lo) cyc($urandom_range(0, 29) != 0, 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
